ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 126 ++++++++++++
 tb/tb_ifetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding imem request, IR holding register, redirect squash.
// Optional stall counter output is enabled by defining IFETCH_STALL_CNT_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR,
  output logic [31:0] IR_PC,
  output logic        ir_valid,
  input  logic        ir_ready
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  // state | meaning
  // IDLE  | no request outstanding; issue when decode has room
  // WAIT  | request outstanding, data will be loaded into IR
  // DRAIN | request outstanding but squashed; its data is dropped
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] ir_q;
  logic [31:0] ir_pc_q;
  logic        req_q;
  logic        valid_q;

  logic        consume;
  logic        can_issue;
  logic [31:0] redirect_pc_d;
  logic        rpc_lsb_unused;

  assign consume        = valid_q && ir_ready;
  assign can_issue      = !stall && !redirect && (!valid_q || ir_ready);
  assign redirect_pc_d  = {redirect_pc[31:2], 2'b00};
  assign rpc_lsb_unused = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ir_q    <= '0;
      ir_pc_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (consume) valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (can_issue) begin
            req_q   <= 1'b1;
            addr_q  <= pc_q;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
            if (!redirect) begin
              ir_q    <= imem_rdata;
              ir_pc_q <= addr_q;
              valid_q <= 1'b1;
              pc_q    <= pc_q + 32'd4;
            end
          end else if (redirect) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
      // Redirect overrides every other PC / IR update in the same cycle.
      if (redirect) begin
        pc_q    <= redirect_pc_d;
        valid_q <= 1'b0;
      end
    end
  end

  assign PC        = pc_q;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign IR        = ir_q;
  assign IR_PC     = ir_pc_q;
  assign ir_valid  = valid_q;

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic        stall_cycle;

  assign stall_cycle = (state_q == WAIT) || (state_q == DRAIN) || (valid_q && !ir_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_cycle && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vector table, reset corners,
// randomized traffic against a transaction-level model, and the optional stall counter.
module tb_ifetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] IR;
  logic [31:0] IR_PC;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ifetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .PC         (PC),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .IR         (IR),
    .IR_PC      (IR_PC),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: inputs applied before an edge, outputs expected just after it.
  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        stl;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ir;
    logic [31:0] e_irpc;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic stl,
                              input logic ack, input logic [31:0] rdata, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_ir, input logic [31:0] e_irpc,
                              input logic [31:0] e_pc);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.stl = stl; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_ir = e_ir; v.e_irpc = e_irpc; v.e_pc = e_pc;
    return v;
  endfunction

  vec_t vec[28];

  // Transaction-level reference: an outstanding fetch (possibly squashed) and an IR slot.
  bit          m_busy;
  bit          m_drop;
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_valid;
  logic [31:0] m_ir;
  logic [31:0] m_irpc;

  task automatic model_reset();
    m_busy = 0; m_drop = 0; m_pc = RST_PC; m_addr = RST_PC;
    m_valid = 0; m_ir = '0; m_irpc = '0;
  endtask

  task automatic model_edge();
    bit deliver;
    bit issue;
    deliver = m_busy && imem_ack && !m_drop && !redirect;
    issue   = !m_busy && !redirect && !stall && (!m_valid || ir_ready);
    if (m_busy && imem_ack) begin
      m_busy = 0;
      m_drop = 0;
    end else if (m_busy && redirect) begin
      m_drop = 1;
    end
    if (deliver) begin
      m_ir = imem_rdata; m_irpc = m_addr; m_valid = 1; m_pc = m_addr + 32'd4;
    end else if (m_valid && ir_ready) begin
      m_valid = 0;
    end
    if (issue) begin
      m_busy = 1;
      m_addr = m_pc;
    end
    if (redirect) begin
      m_pc    = redirect_pc & ~32'd3;
      m_valid = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 0; stall = 0; imem_ack = 0; ir_ready = 0;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] A0, A1, A2, A3, A4, A5, A6, A7;
    A0 = 32'h1111_0000; A1 = 32'h2222_0001; A2 = 32'h3333_0002; A3 = 32'h4444_0003;
    A4 = 32'h5555_0004; A5 = 32'h6666_0005; A6 = 32'h7777_0006; A7 = 32'h8888_0007;

    vec[0]  = mk(0, 0, 0, 0, 0, 1,  1, 32'h3000, 0, 0, 0, 32'h3000);
    vec[1]  = mk(0, 0, 0, 1, A0, 1, 0, 0, 1, A0, 32'h3000, 32'h3004);
    vec[2]  = mk(0, 0, 0, 0, 0, 1,  1, 32'h3004, 0, 0, 0, 32'h3004);
    vec[3]  = mk(0, 0, 0, 1, A1, 1, 0, 0, 1, A1, 32'h3004, 32'h3008);
    vec[4]  = mk(0, 0, 0, 0, 0, 1,  1, 32'h3008, 0, 0, 0, 32'h3008);
    vec[5]  = mk(0, 0, 0, 1, A2, 0, 0, 0, 1, A2, 32'h3008, 32'h300C);
    for (int i = 6; i <= 10; i++)
      vec[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, A2, 32'h3008, 32'h300C);
    vec[11] = mk(0, 0, 0, 0, 0, 1,  1, 32'h300C, 0, 0, 0, 32'h300C);
    vec[12] = mk(0, 0, 0, 1, A3, 0, 0, 0, 1, A3, 32'h300C, 32'h3010);
    vec[13] = mk(0, 0, 0, 0, 0, 1,  1, 32'h3010, 0, 0, 0, 32'h3010);
    vec[14] = mk(1, 32'h4003, 0, 0, 0, 0, 1, 32'h3010, 0, 0, 0, 32'h4000);
    vec[15] = mk(0, 0, 0, 0, 0, 0,  1, 32'h3010, 0, 0, 0, 32'h4000);
    vec[16] = mk(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 32'h4000);
    vec[17] = mk(0, 0, 0, 0, 0, 0,  1, 32'h4000, 0, 0, 0, 32'h4000);
    vec[18] = mk(0, 0, 0, 1, A4, 0, 0, 0, 1, A4, 32'h4000, 32'h4004);
    vec[19] = mk(0, 0, 0, 0, 0, 1,  1, 32'h4004, 0, 0, 0, 32'h4004);
    vec[20] = mk(1, 32'h5000, 0, 1, 32'hBAD0_BAD0, 0, 0, 0, 0, 0, 0, 32'h5000);
    vec[21] = mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 32'h5000);
    vec[22] = mk(0, 0, 0, 0, 0, 0,  1, 32'h5000, 0, 0, 0, 32'h5000);
    vec[23] = mk(0, 0, 0, 1, A5, 0, 0, 0, 1, A5, 32'h5000, 32'h5004);
    vec[24] = mk(1, 32'hFFFF_FFFE, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    vec[25] = mk(0, 0, 0, 0, 0, 0,  1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC);
    vec[26] = mk(0, 0, 0, 1, A6, 0, 0, 0, 1, A6, 32'hFFFF_FFFC, 32'h0);
    vec[27] = mk(0, 0, 0, 0, 0, 1,  1, 32'h0, 0, 0, 0, 32'h0);

    // Reset state
    tick();
    tick();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_pc", PC, RST_PC);
    chk("rst_valid", {31'b0, ir_valid}, 32'h0);
    chk("rst_ir", IR, 32'h0);
    chk("rst_irpc", IR_PC, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      redirect = vec[i].redir; redirect_pc = vec[i].rpc; stall = vec[i].stl;
      imem_ack = vec[i].ack;   imem_rdata = vec[i].rdata; ir_ready = vec[i].rdy;
      tick();
      chk($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vec[i].e_req});
      if (vec[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, vec[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'b0, ir_valid}, {31'b0, vec[i].e_valid});
      if (vec[i].e_valid) begin
        chk($sformatf("vec%0d_ir", i), IR, vec[i].e_ir);
        chk($sformatf("vec%0d_irpc", i), IR_PC, vec[i].e_irpc);
      end
      chk($sformatf("vec%0d_pc", i), PC, vec[i].e_pc);
    end

    // Reset while a request is outstanding: request drops immediately, late ack ignored.
    redirect = 0; imem_ack = 0; ir_ready = 0; stall = 0;
    #3;
    rst = 1'b1;
    #1;
    chk("midwait_req", {31'b0, imem_req}, 32'h0);
    chk("midwait_pc", PC, RST_PC);
    chk("midwait_addr", imem_addr, RST_PC);
    stall = 1; imem_ack = 1; imem_rdata = 32'hBADB_ADBA;
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("late_ack_req", {31'b0, imem_req}, 32'h0);
    chk("late_ack_valid", {31'b0, ir_valid}, 32'h0);
    stall = 0; imem_ack = 0;
    tick();
    chk("post_rst_req", {31'b0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr, RST_PC);
    imem_ack = 1; imem_rdata = A7;
    tick();
    chk("post_rst_ir", IR, A7);
    chk("post_rst_irpc", IR_PC, RST_PC);
    imem_ack = 0;

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom;
      stall       = ($urandom_range(0, 3) == 0);
      ir_ready    = ($urandom_range(0, 9) < 7);
      imem_ack    = imem_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      imem_rdata  = $urandom;
      model_edge();
      tick();
      chk("rnd_req", {31'b0, imem_req}, {31'b0, m_busy});
      if (m_busy) chk("rnd_addr", imem_addr, m_addr);
      chk("rnd_valid", {31'b0, ir_valid}, {31'b0, m_valid});
      if (m_valid) begin
        chk("rnd_ir", IR, m_ir);
        chk("rnd_irpc", IR_PC, m_irpc);
      end
      chk("rnd_pc", PC, m_pc);
    end

`ifdef IFETCH_STALL_CNT_EN
    // 3-cycle ack latency then 2 cycles of back-pressure.
    do_reset();
    stall = 0; ir_ready = 0; imem_ack = 0;
    tick();
    chk("cnt_issue", stall_cnt, 32'd0);
    stall = 1;
    tick();
    tick();
    imem_ack = 1; imem_rdata = A0;
    tick();
    imem_ack = 0;
    chk("cnt_wait", stall_cnt, 32'd3);
    tick();
    tick();
    ir_ready = 1;
    tick();
    chk("cnt_total", stall_cnt, 32'd5);
    tick();
    chk("cnt_hold", stall_cnt, 32'd5);
    // Saturation: preset the counter, keep the unit waiting on memory.
    stall = 0;
    tick();
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    stall = 1;
    tick();
    tick();
    chk("cnt_sat", stall_cnt, 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
